// File: rtl/bcd_2digit_down_pkg.sv
// Shared BCD definitions for the two-digit BCD counters (up and down variants).
// Digit limits, the digit type and a validity check used on load presets.
package bcd_2digit_down_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic bcd_is_valid(input bcd_digit_t digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Single BCD digit down counter: loads a preset, decrements 0 -> 9 on underflow.
// The caller decides when a decrement is allowed and only presents valid BCD loads.
module bcd_down_counter
  import bcd_2digit_down_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       decr,
  output bcd_digit_t num,
  output logic       min
);

  bcd_digit_t num_r;
  bcd_digit_t num_next_s;

  // Next digit value: load wins over decrement; out-of-range state recovers to 9.
  always_comb begin
    num_next_s = num_r;
    if (load) begin
      num_next_s = load_val;
    end else if (decr) begin
      if ((num_r == BCD_MIN) || !bcd_is_valid(num_r)) begin
        num_next_s = BCD_MAX;
      end else begin
        num_next_s = num_r - 4'd1;
      end
    end else begin
      num_next_s = num_r;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      num_r <= BCD_MIN;
    end else begin
      num_r <= num_next_s;
    end
  end

  assign num = num_r;
  assign min = (num_r == BCD_MIN);

endmodule

// File: rtl/bcd_2digit_down.sv
// Two-digit BCD down counter with load validation, zero flag and either
// wrap-to-99 (with a borrow pulse) or saturation at 00, selected by WRAP.
module bcd_2digit_down
  import bcd_2digit_down_pkg::*;
#(
  parameter int unsigned WRAP = 1
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       load,
  input  logic [3:0] load_num0,
  input  logic [3:0] load_num1,
  input  logic       decr,
  output logic [3:0] num0,
  output logic [3:0] num1,
  output logic       zero,
  output logic       borrow,
  output logic       load_err
);

  localparam logic WRAP_EN = (WRAP != 32'd0);

  logic min0_s;
  logic min1_s;
  logic zero_s;
  logic load_ok_s;
  logic digit_load_s;
  logic units_decr_s;
  logic tens_decr_s;
  logic borrow_r;
  logic load_err_r;

  assign zero_s       = min0_s & min1_s;
  assign load_ok_s    = bcd_is_valid(load_num0) & bcd_is_valid(load_num1);
  assign digit_load_s = load & load_ok_s;
  // A rejected load still blocks decr; saturation blocks decr at 00.
  assign units_decr_s = decr & ~load & ~(zero_s & ~WRAP_EN);
  assign tens_decr_s  = units_decr_s & min0_s;

  bcd_down_counter u_units (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (digit_load_s),
    .load_val (load_num0),
    .decr     (units_decr_s),
    .num      (num0),
    .min      (min0_s)
  );

  bcd_down_counter u_tens (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (digit_load_s),
    .load_val (load_num1),
    .decr     (tens_decr_s),
    .num      (num1),
    .min      (min1_s)
  );

  // One-cycle status pulses for a 00 -> 99 wrap and for a rejected load.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      borrow_r   <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      borrow_r   <= units_decr_s & zero_s & WRAP_EN;
      load_err_r <= load & ~load_ok_s;
    end
  end

  assign zero     = zero_s;
  assign borrow   = borrow_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_2digit_down.sv
// Self-checking bench for bcd_2digit_down: directed vector table, corner-case
// sequences, and a random stream against a reference model for both WRAP settings.
module tb_bcd_2digit_down;

  logic       clk;
  logic       rst_b;
  logic       load;
  logic [3:0] load_num0;
  logic [3:0] load_num1;
  logic       decr;

  logic [3:0] w_num0, w_num1, s_num0, s_num1;
  logic       w_zero, w_borrow, w_err, s_zero, s_borrow, s_err;

  int tests;
  int fails;

  bcd_2digit_down #(.WRAP(1)) dut_wrap (
    .clk(clk), .rst_b(rst_b), .load(load), .load_num0(load_num0), .load_num1(load_num1),
    .decr(decr), .num0(w_num0), .num1(w_num1), .zero(w_zero), .borrow(w_borrow),
    .load_err(w_err)
  );

  bcd_2digit_down #(.WRAP(0)) dut_sat (
    .clk(clk), .rst_b(rst_b), .load(load), .load_num0(load_num0), .load_num1(load_num1),
    .decr(decr), .num0(s_num0), .num1(s_num1), .zero(s_zero), .borrow(s_borrow),
    .load_err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [3:0] ln0;
    logic [3:0] ln1;
    logic       dc;
    logic [3:0] e0;
    logic [3:0] e1;
    logic       ez;
    logic       eb;
    logic       ee;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Apply inputs, take one rising edge, settle just after it.
  task automatic step(input logic l, input logic [3:0] n0, input logic [3:0] n1, input logic d);
    load = l; load_num0 = n0; load_num1 = n1; decr = d;
    @(posedge clk);
    #1;
  endtask

  // Reference model of one counter edge.
  task automatic model(input logic wrap, input logic l, input logic [3:0] n0,
                       input logic [3:0] n1, input logic d,
                       inout int m0, inout int m1, output int b, output int e);
    b = 0; e = 0;
    if (l) begin
      if (n0 <= 4'd9 && n1 <= 4'd9) begin m0 = n0; m1 = n1; end
      else e = 1;
    end else if (d) begin
      if (m0 > 0) m0 = m0 - 1;
      else if (m1 > 0) begin m0 = 9; m1 = m1 - 1; end
      else if (wrap) begin m0 = 9; m1 = 9; b = 1; end
    end
  endtask

  function automatic vec_t mk(logic ld, int ln1, int ln0, logic dc, int e1, int e0,
                              logic ez, logic eb, logic ee);
    vec_t v;
    v.ld = ld; v.ln0 = 4'(ln0); v.ln1 = 4'(ln1); v.dc = dc;
    v.e0 = 4'(e0); v.e1 = 4'(e1); v.ez = ez; v.eb = eb; v.ee = ee;
    return v;
  endfunction

  initial begin
    int bcount;
    int m0w, m1w, m0s, m1s, bw, ew, bs, es;
    logic rl, rd;
    logic [3:0] r0, r1;

    tests = 0; fails = 0;
    rst_b = 1'b0; load = 1'b0; load_num0 = 4'd0; load_num1 = 4'd0; decr = 1'b0;

    //                ld  tens units dc  e1 e0 z  b  err
    vecs.push_back(mk(1'b1, 2, 0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 0, 0, 1'b1, 1, 9, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4, 2, 1'b0, 4, 2, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 7, 3, 1'b1, 7, 3, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 7, 10, 1'b1, 7, 3, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 0, 0, 1'b0, 7, 3, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 11, 3, 1'b0, 7, 3, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1, 0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 0, 0, 1'b1, 0, 9, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 0, 0, 1'b1, 0, 8, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 0, 0, 1'b1, 9, 9, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 0, 0, 1'b0, 9, 9, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 0, 0, 1'b1, 9, 8, 1'b0, 1'b0, 1'b0));

    // Reset state
    #12;
    check("reset_num0", w_num0, 0);
    check("reset_num1", w_num1, 0);
    check("reset_zero", w_zero, 1);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    // Directed vector table
    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].ln0, vecs[i].ln1, vecs[i].dc);
      check($sformatf("vec%0d_num0", i), w_num0, vecs[i].e0);
      check($sformatf("vec%0d_num1", i), w_num1, vecs[i].e1);
      check($sformatf("vec%0d_zero", i), w_zero, vecs[i].ez);
      check($sformatf("vec%0d_borrow", i), w_borrow, vecs[i].eb);
      check($sformatf("vec%0d_load_err", i), w_err, vecs[i].ee);
    end

    // Reset asserted between edges mid-count
    step(1'b1, 4'd7, 4'd5, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 4'd0, 1'b1);
    check("mid_pre_num0", w_num0, 4);
    #2 rst_b = 1'b0;
    #1;
    check("mid_rst_num0", w_num0, 0);
    check("mid_rst_num1", w_num1, 0);
    check("mid_rst_zero", w_zero, 1);
    check("mid_rst_borrow", w_borrow, 0);
    check("mid_rst_err", w_err, 0);
    check("mid_rst_sat_num0", s_num0, 0);
    @(negedge clk);
    rst_b = 1'b1;

    // Borrow across digits: 20 -> 19 -> ... -> 00
    step(1'b1, 4'd0, 4'd2, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1);
    check("b20_num1", w_num1, 1);
    check("b20_num0", w_num0, 9);
    check("b20_zero", w_zero, 0);
    for (int i = 0; i < 19; i++) step(1'b0, 4'd0, 4'd0, 1'b1);
    check("b20_end_num1", w_num1, 0);
    check("b20_end_num0", w_num0, 0);
    check("b20_end_zero", w_zero, 1);

    // 100 decrements from 00 with WRAP=1: back to 00, exactly one borrow
    step(1'b1, 4'd0, 4'd0, 1'b0);
    bcount = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 4'd0, 4'd0, 1'b1);
      if (w_borrow) bcount++;
      if (i == 0) begin
        check("wrap_first_num0", w_num0, 9);
        check("wrap_first_num1", w_num1, 9);
        check("wrap_first_borrow", w_borrow, 1);
      end
      if (i == 1) check("wrap_second_borrow", w_borrow, 0);
    end
    check("wrap100_num0", w_num0, 0);
    check("wrap100_num1", w_num1, 0);
    check("wrap100_borrow_count", bcount, 1);

    // Saturation with WRAP=0
    step(1'b1, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'd0, 4'd0, 1'b1);
      check($sformatf("sat%0d_num", i), {s_num1, s_num0}, 0);
      check($sformatf("sat%0d_borrow", i), s_borrow, 0);
      check($sformatf("sat%0d_zero", i), s_zero, 1);
    end

    // Random stream against the reference model, both WRAP settings
    step(1'b1, 4'd0, 4'd0, 1'b0);
    m0w = 0; m1w = 0; m0s = 0; m1s = 0;
    for (int i = 0; i < 400; i++) begin
      rl = ($urandom_range(3) == 0);
      rd = ($urandom_range(3) != 0);
      r0 = 4'($urandom_range(15));
      r1 = 4'($urandom_range(15));
      model(1'b1, rl, r0, r1, rd, m0w, m1w, bw, ew);
      model(1'b0, rl, r0, r1, rd, m0s, m1s, bs, es);
      step(rl, r0, r1, rd);
      check("rnd_w_digits", {w_num1, w_num0}, m1w * 16 + m0w);
      check("rnd_w_zero", w_zero, (m0w == 0 && m1w == 0));
      check("rnd_w_borrow", w_borrow, bw);
      check("rnd_w_err", w_err, ew);
      check("rnd_w_range", (w_num0 <= 4'd9 && w_num1 <= 4'd9), 1);
      check("rnd_s_digits", {s_num1, s_num0}, m1s * 16 + m0s);
      check("rnd_s_borrow", s_borrow, bs);
      check("rnd_s_err", s_err, es);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_2digit_down.md
# bcd_2digit_down

Two-digit BCD down counter: the decrementing counterpart of the team's two-digit BCD up counter, used for countdown timers and remaining-count displays. It loads a two-digit BCD preset (00–99), decrements once per cycle in which `decr` is high, and flags zero. It also flags wrap-around, or saturates at 00, depending on the `WRAP` parameter. Each digit is one instance of a single-digit BCD down counter. The digits are chained by borrow, mirroring the carry chain of the up counter.

## Interface
- `WRAP`, default 1: 1 = decrement at 00 wraps to 99 and pulses `borrow`; 0 = decrement at 00 holds 00, no `borrow`.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_b`  input  1  reset, asynchronous, active-low.
- `load`  input  1  load the preset `load_num1`:`load_num0`; has priority over `decr`.
- `load_num0`  input  4  preset units digit, BCD.
- `load_num1`  input  4  preset tens digit, BCD.
- `decr`  input  1  decrement-by-one request, sampled each rising edge.
- `num0`  output  4  units digit, registered.
- `num1`  output  4  tens digit, registered.
- `zero`  output  1  high when `num1`==0 and `num0`==0; decoded combinationally from the digit registers only.
- `borrow`  output  1  registered one-cycle pulse on a 99 wrap (`WRAP`=1 only).
- `load_err`  output  1  registered one-cycle pulse when a `load` was rejected.

## Operation
- **Reset** (`rst_b` low, asynchronous, any time including mid-count):
  - `num0`=0, `num1`=0, `borrow`=0, `load_err`=0.
  - `zero`=1 as a consequence of the digit values.
  - Release takes effect at the next rising edge.
- **Per-edge priority:** `load` > `decr` > hold.
- **`load`=1:**
  - If both preset digits are ≤9, `num0`/`num1` take them and `load_err`=0.
  - If either preset digit is >9, the whole load is rejected, both digits hold, and `load_err`=1 for one cycle.
  - `decr` is ignored that cycle in both cases, including a rejected load.
- **`decr`=1, `load`=0:**
  - `num0` > 0: `num0` -= 1; `num1` holds.
  - `num0` = 0, `num1` > 0: `num0` ← 9; `num1` -= 1.
  - Both 0, `WRAP`=1: `num0` ← 9, `num1` ← 9, `borrow`=1 for the following cycle.
  - Both 0, `WRAP`=0: hold 00; `borrow` stays 0.
- **Idle:** `borrow` and `load_err` are 0 on every edge that does not set them. Neither output is ever held for two cycles by a single event.
- **Digit chain:** the tens digit decrements only when `decr` is high and the units digit is at 0, which is its borrow-in.
- **Invariant:** digit registers never hold values >9, whatever the stimulus.

## Timing
- **Latency:** 1 cycle from a sampled `load`/`decr` to the new `num0`/`num1`.
- **`zero`:** valid in the same cycle as the digit values it describes; no additional register.
- **`borrow`:** high in exactly the cycle `num1`:`num0` first shows 99 after a wrap.
- **`load_err`:** high in the cycle after the rejected `load` edge.
- **Throughput:** back-to-back `decr` every cycle decrements every cycle; 100 consecutive decrements from 00 with `WRAP`=1 return to 00 with exactly one `borrow` pulse.

## Structure
- **Shared package:** `BCD_MAX`=4'd9, `BCD_MIN`=4'd0, and a 4-bit BCD digit typedef, reused by the up counter.
- **Sub-module `bcd_down_counter`:** one digit.
  - Ports: `clk`, `rst_b`, `load`, `load_val`, `decr`, `num`, `min` (`num`==0).
  - Instantiated twice.
  - The top holds the `WRAP`/saturation gating, the load validity check, and the `borrow`/`load_err` registers.

## Test plan
- **Reset mid-count:** load 57, decrement 3 cycles, assert `rst_b` low between edges → `num`=00 immediately, `zero`=1, `borrow`=0, `load_err`=0.
- **Borrow across digits:** load 20, `decr` for 1 cycle → 19 next cycle, `zero`=0; continue for 19 more cycles → 00, `zero`=1.
- **Wrap, `WRAP`=1:** at 00, `decr` once → 99 with `borrow`=1 that cycle only. Then 100 consecutive decrements → 00 with exactly one `borrow` pulse.
- **Saturate, `WRAP`=0:** at 00, `decr` held 5 cycles → stays 00, `borrow` never 1, `zero` stays 1.
- **Load priority and rejection:**
  - At 42, `load`=1 with preset 73 and `decr`=1 → 73, not 72.
  - `load` with `load_num0`=4'hA → digits stay 73, `load_err`=1 for one cycle.
- **Random check:** random `load`/`decr` streams against a reference model → digits always ≤9 and match the model every cycle.
